shift_arb_seq: RTL and testbench

- Two-requester controller for the 4-bit right-shift datapath.
- Arbitrates round-robin between port 0 and port 1 and accepts one request at a time.
- Executes the shift iteratively: the shifter unit moves at most 3 bit positions per cycle, so larger amounts take several cycles.
- Returns the result with a valid/ready handshake. Sits between ALU issue logic and the shared shifter.

---
 rtl/shift_arb_seq.sv | 92 +++++++++
 tb/tb_shift_arb_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arb_seq.sv
// shift_arb_seq: round-robin two-port arbiter feeding an iterative 4-bit right shifter.
// Shifts at most MAXSTEP positions per cycle; the result is held until the consumer takes it.
module shift_arb_seq #(
    parameter int DW      = 4,
    parameter int AW      = 3,
    parameter int MAXSTEP = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_data,
    input  logic [AW-1:0] req0_amt,
    input  logic          req0_arith,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_data,
    input  logic [AW-1:0] req1_amt,
    input  logic          req1_arith,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic          res_id,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [DW-1:0]        r_data;
    logic [AW-1:0]        r_rem;
    logic                 r_arith;
    logic                 r_id;
    logic                 r_last;
    logic                 w_gnt0;
    logic                 w_gnt1;
    logic                 w_acc;
    logic [AW-1:0]        w_amt;
    logic [AW-1:0]        w_step;
    logic signed [DW-1:0] w_sra;
    logic [DW-1:0]        w_shifted;

    // r_last remembers the most recent grant; a tie goes to the other port
    always_comb begin
        w_gnt1     = req1_valid & (~req0_valid | ~r_last);
        w_gnt0     = req0_valid & ~w_gnt1;
        req0_ready = (r_state == IDLE) & w_gnt0;
        req1_ready = (r_state == IDLE) & w_gnt1;
        w_acc      = req0_ready | req1_ready;
        w_amt      = w_gnt1 ? req1_amt : req0_amt;
        w_step     = (r_rem > AW'(MAXSTEP)) ? AW'(MAXSTEP) : r_rem;
        w_sra      = $signed(r_data) >>> w_step;
        w_shifted  = r_arith ? w_sra : (r_data >> w_step);
        res_valid  = r_state == DONE;
        res_data   = r_data;
        res_id     = r_id;
        busy       = r_state != IDLE;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_acc ? ((w_amt != '0) ? SHIFT : DONE) : IDLE;
            SHIFT:   w_next = (r_rem == w_step) ? DONE : SHIFT;
            DONE:    w_next = res_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_rem   <= '0;
            r_arith <= 1'b0;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_acc) begin
                r_data  <= w_gnt1 ? req1_data : req0_data;
                r_rem   <= w_amt;
                r_arith <= w_gnt1 ? req1_arith : req0_arith;
                r_id    <= w_gnt1;
                r_last  <= w_gnt1;
            end else if (r_state == SHIFT) begin
                r_data <= w_shifted;
                r_rem  <= r_rem - w_step;
            end
        end
    end
endmodule

// File: tb/tb_shift_arb_seq.sv
// tb_shift_arb_seq: directed scenarios plus a randomized run checked against a
// behavioural model of the arbiter and of a right shift as floor division.
module tb_shift_arb_seq;
    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req0_arith;
    logic [3:0] req0_data;
    logic [2:0] req0_amt;
    logic       req1_valid, req1_ready, req1_arith;
    logic [3:0] req1_data;
    logic [2:0] req1_amt;
    logic       res_valid, res_ready, res_id, busy;
    logic [3:0] res_data;

    int n_tests = 0;
    int n_fail  = 0;
    bit m_last;

    always #5 clk = ~clk;

    shift_arb_seq dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_amt(req0_amt), .req0_arith(req0_arith),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_amt(req1_amt), .req1_arith(req1_arith),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_id(res_id), .busy(busy)
    );

    // Right shift by a as floor division of the (optionally signed) operand by 2**a
    function automatic logic [3:0] ref_shift(logic [3:0] d, int a, bit ar);
        int v, p;
        v = (ar && d[3]) ? int'(d) - 16 : int'(d);
        p = 1 << a;
        v = (v >= 0) ? v / p : -((-v + p - 1) / p);
        return 4'(v);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_last = 1'b1;
        #1;
    endtask

    // Presents one request, waits for its grant, then waits for res_valid.
    // lat counts clock edges from the accept edge (inclusive) to res_valid.
    task automatic issue(input bit p, input logic [3:0] d, input logic [2:0] a, input bit ar,
                         output bit gp, output int lat);
        int n;
        @(negedge clk);
        if (p) begin
            req1_valid = 1'b1; req1_data = d; req1_amt = a; req1_arith = ar;
        end else begin
            req0_valid = 1'b1; req0_data = d; req0_amt = a; req0_arith = ar;
        end
        #1;
        n = 0;
        while (!(req0_ready || req1_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        gp = req1_ready;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lat = (n < 20) ? 1 : 99;
        #1;
        while (!res_valid && lat < 10) begin
            @(negedge clk); #1; lat++;
        end
        if (gp == p) m_last = p;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_last = 1'b1;
        #1;
        n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", res_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready}); end
        n_tests++; if (res_data !== 4'd0) begin n_fail++; $display("FAIL reset_data got %b want 0000", res_data); end
    endtask

    task automatic test_logical();
        bit gp; int lat;
        res_ready = 1'b1;
        issue(1'b0, 4'b1011, 3'd2, 1'b0, gp, lat);
        n_tests++; if (gp !== 1'b0) begin n_fail++; $display("FAIL log_grant got %0d want 0", gp); end
        n_tests++; if (lat != 2) begin n_fail++; $display("FAIL log_latency got %0d want 2", lat); end
        n_tests++; if (res_data !== ref_shift(4'b1011, 2, 1'b0)) begin n_fail++; $display("FAIL log_data got %b want %b", res_data, ref_shift(4'b1011, 2, 1'b0)); end
        n_tests++; if (res_id !== 1'b0) begin n_fail++; $display("FAIL log_id got %b want 0", res_id); end
        @(negedge clk); #1;
        n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL log_pulse got %b want 0", res_valid); end
    endtask

    task automatic test_arith7();
        bit gp; int lat;
        res_ready = 1'b1;
        issue(1'b1, 4'b1000, 3'd7, 1'b1, gp, lat);
        n_tests++; if (gp !== 1'b1) begin n_fail++; $display("FAIL ar7_grant got %0d want 1", gp); end
        n_tests++; if (lat != 4) begin n_fail++; $display("FAIL ar7_latency got %0d want 4", lat); end
        n_tests++; if (res_data !== 4'b1111) begin n_fail++; $display("FAIL ar7_data got %b want 1111", res_data); end
        n_tests++; if (res_id !== 1'b1) begin n_fail++; $display("FAIL ar7_id got %b want 1", res_id); end
        @(negedge clk); #1;
    endtask

    task automatic test_backpressure();
        bit gp; int lat;
        res_ready = 1'b0;
        issue(1'b0, 4'b0110, 3'd0, 1'b0, gp, lat);
        n_tests++; if (lat != 1) begin n_fail++; $display("FAIL bp_latency got %0d want 1", lat); end
        req1_valid = 1'b1; req1_data = 4'b0001; req1_amt = 3'd1; req1_arith = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            n_tests++; if (res_valid !== 1'b1 || res_data !== 4'b0110) begin n_fail++; $display("FAIL bp_hold[%0d] got v=%b d=%b want v=1 d=0110", i, res_valid, res_data); end
            n_tests++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL bp_ready[%0d] got %b want 00", i, {req0_ready, req1_ready}); end
        end
        @(negedge clk);
        res_ready = 1'b1;
        req1_valid = 1'b0;
        @(negedge clk); #1;
        n_tests++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_release got v=%b busy=%b want 0 0", res_valid, busy); end
    endtask

    task automatic test_round_robin();
        int n; bit g; logic [3:0] exp;
        do_reset();
        res_ready = 1'b1;
        req0_data = 4'($urandom); req0_amt = 3'($urandom); req0_arith = 1'($urandom);
        req1_data = req0_data ^ 4'd5; req1_amt = 3'($urandom); req1_arith = 1'($urandom);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(req0_ready || req1_ready) && n < 20) begin @(negedge clk); #1; n++; end
            g = req1_ready;
            n_tests++; if (n >= 20 || (req0_ready && req1_ready) || g != k[0]) begin n_fail++; $display("FAIL rr_grant[%0d] got r0=%b r1=%b want port %0d", k, req0_ready, req1_ready, k[0]); end
            exp = g ? ref_shift(req1_data, int'(req1_amt), req1_arith) : ref_shift(req0_data, int'(req0_amt), req0_arith);
            @(negedge clk);
            if (g) begin req1_data = 4'($urandom); req1_amt = 3'($urandom); req1_arith = 1'($urandom); end
            else begin req0_data = 4'($urandom); req0_amt = 3'($urandom); req0_arith = 1'($urandom); end
            #1;
            n = 0;
            while (!res_valid && n < 10) begin @(negedge clk); #1; n++; end
            n_tests++; if (res_valid !== 1'b1 || res_id !== g || res_data !== exp) begin n_fail++; $display("FAIL rr_result[%0d] got v=%b id=%b d=%b want v=1 id=%0d d=%b", k, res_valid, res_id, res_data, g, exp); end
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_mid_reset();
        int n; bit gp; int lat;
        do_reset();
        res_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 4'b1010; req0_amt = 3'd7; req0_arith = 1'b1;
        #1;
        n = 0;
        while (!req0_ready && n < 20) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk); #1;
        n_tests++; if (busy !== 1'b1 || res_valid !== 1'b0) begin n_fail++; $display("FAIL mr_shifting got busy=%b v=%b want 1 0", busy, res_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_last = 1'b1;
        #1;
        n_tests++; if (busy !== 1'b0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL mr_idle got busy=%b v=%b want 0 0", busy, res_valid); end
        issue(1'b1, 4'b1101, 3'd3, 1'b1, gp, lat);
        n_tests++; if (gp !== 1'b1 || lat != 2) begin n_fail++; $display("FAIL mr_after got port=%0d lat=%0d want 1 2", gp, lat); end
        n_tests++; if (res_data !== ref_shift(4'b1101, 3, 1'b1) || res_id !== 1'b1) begin n_fail++; $display("FAIL mr_result got d=%b id=%b want %b 1", res_data, res_id, ref_shift(4'b1101, 3, 1'b1)); end
        @(negedge clk); #1;
    endtask

    // Free-running random traffic; the model tracks idle/busy, pending cycles and the tie pointer
    task automatic test_random();
        bit m_busy, m_id, e0, e1, ev;
        int m_cnt;
        logic [3:0] m_data;
        do_reset();
        m_busy = 1'b0; m_cnt = 0; m_id = 1'b0; m_data = 4'd0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            req0_valid = 1'($urandom); req0_data = 4'($urandom); req0_amt = 3'($urandom); req0_arith = 1'($urandom);
            req1_valid = 1'($urandom); req1_data = 4'($urandom); req1_amt = 3'($urandom); req1_arith = 1'($urandom);
            res_ready = 1'($urandom);
            #1;
            e1 = !m_busy && req1_valid && (!req0_valid || !m_last);
            e0 = !m_busy && req0_valid && !e1;
            ev = m_busy && m_cnt == 0;
            n_tests++; if ({req0_ready, req1_ready} !== {e0, e1}) begin n_fail++; $display("FAIL rnd_ready[%0d] got %b want %b", c, {req0_ready, req1_ready}, {e0, e1}); end
            n_tests++; if (res_valid !== ev || busy !== m_busy) begin n_fail++; $display("FAIL rnd_status[%0d] got v=%b busy=%b want %b %b", c, res_valid, busy, ev, m_busy); end
            if (ev) begin
                n_tests++; if (res_data !== m_data || res_id !== m_id) begin n_fail++; $display("FAIL rnd_result[%0d] got d=%b id=%b want %b %b", c, res_data, res_id, m_data, m_id); end
            end
            if (e0 || e1) begin
                m_busy = 1'b1; m_last = e1; m_id = e1;
                m_data = e1 ? ref_shift(req1_data, int'(req1_amt), req1_arith) : ref_shift(req0_data, int'(req0_amt), req0_arith);
                m_cnt = ((e1 ? int'(req1_amt) : int'(req0_amt)) + 2) / 3;
            end else if (m_busy) begin
                if (m_cnt > 0) m_cnt--;
                else if (res_ready) m_busy = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; res_ready = 1'b0;
        req0_valid = 1'b0; req0_data = '0; req0_amt = '0; req0_arith = 1'b0;
        req1_valid = 1'b0; req1_data = '0; req1_amt = '0; req1_arith = 1'b0;
        m_last = 1'b1;
        test_reset();
        test_logical();
        test_arith7();
        test_backpressure();
        test_round_robin();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
